// File: rtl/pixel_plot_arbiter_if.sv
// Pixel bus between the two sprite sources and the VGA adapter write port.
// The master side drives sprite pixels in; the slave side is the arbiter.
interface pixel_plot_arbiter_if;
  logic       s0_valid;
  logic       s0_ready;
  logic [7:0] s0_x;
  logic [6:0] s0_y;
  logic [2:0] s0_colour;

  logic       s1_valid;
  logic       s1_ready;
  logic [7:0] s1_x;
  logic [6:0] s1_y;
  logic [2:0] s1_colour;

  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [7:0] clip_count;

  modport master (
    output s0_valid, s0_x, s0_y, s0_colour,
    output s1_valid, s1_x, s1_y, s1_colour,
    input  s0_ready, s1_ready,
    input  x, y, colour, plot, clip_count
  );

  modport slave (
    input  s0_valid, s0_x, s0_y, s0_colour,
    input  s1_valid, s1_x, s1_y, s1_colour,
    output s0_ready, s1_ready,
    output x, y, colour, plot, clip_count
  );
endinterface

// File: rtl/pixel_plot_arbiter.sv
// Merges comet (source 0) and player/star (source 1) pixel streams into
// one registered VGA write port through clipped per-source FIFOs.
module pixel_plot_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic                 clock,
  input  logic                 reset,
  pixel_plot_arbiter_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [8:0]    LIM_X = 9'(SCREEN_W);
  localparam logic [7:0]    LIM_Y = 8'(SCREEN_H);

  typedef logic [17:0] pix_t;

  pix_t          mem [2][DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [CW-1:0] count [2];
  logic          last_grant;

  logic [7:0]    x_q;
  logic [6:0]    y_q;
  logic [2:0]    colour_q;
  logic          plot_q;
  logic [7:0]    clip_q;

  pix_t          in_pix [2];
  logic [1:0]    valid;
  logic [1:0]    ready;
  logic [1:0]    take;
  logic [1:0]    clip;
  logic [1:0]    push;
  logic [1:0]    busy;
  logic [1:0]    pop;
  logic [1:0]    clip_add;
  logic [8:0]    clip_sum;

  always_comb begin
    valid     = {bus.s1_valid, bus.s0_valid};
    in_pix[0] = {bus.s0_x, bus.s0_y, bus.s0_colour};
    in_pix[1] = {bus.s1_x, bus.s1_y, bus.s1_colour};
    ready     = '0;
    busy      = '0;
    take      = '0;
    clip      = '0;
    push      = '0;
    for (int i = 0; i < 2; i++) begin
      ready[i] = count[i] != FULL;
      busy[i]  = count[i] != '0;
      take[i]  = valid[i] && ready[i];
      clip[i]  = ({1'b0, in_pix[i][17:10]} >= LIM_X)
              || ({1'b0, in_pix[i][9:3]} >= LIM_Y);
      push[i]  = take[i] && !clip[i];
    end
    // last_grant names the source that must yield under contention
    pop[0]   = busy[0] && (!busy[1] || last_grant);
    pop[1]   = busy[1] && (!busy[0] || !last_grant);
    clip_add = {1'b0, take[0] & clip[0]}
             + {1'b0, take[1] & clip[1]};
    clip_sum = {1'b0, clip_q} + {7'b0, clip_add};
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_pix[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        unique case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      clip_q     <= '0;
      last_grant <= 1'b1;
    end else begin
      plot_q <= |pop;
      if (pop[0]) begin
        {x_q, y_q, colour_q} <= mem[0][rd_ptr[0]];
      end else if (pop[1]) begin
        {x_q, y_q, colour_q} <= mem[1][rd_ptr[1]];
      end
      if (&busy) last_grant <= pop[1];
      clip_q <= clip_sum[8] ? 8'hFF : clip_sum[7:0];
    end
  end

  assign bus.s0_ready   = ready[0];
  assign bus.s1_ready   = ready[1];
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.plot       = plot_q;
  assign bus.clip_count = clip_q;
endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Self-checking bench for pixel_plot_arbiter: vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_pixel_plot_arbiter;
  localparam int DEPTH = 4;

  typedef logic [17:0] pix_t;

  typedef struct {
    bit v0; int x0; int y0; int c0;
    bit v1; int x1; int y1; int c1;
    bit plot; int x; int y; int c; int clip;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pixel_plot_arbiter_if bus();

  pixel_plot_arbiter #(
    .DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  pix_t q0[$];
  pix_t q1[$];
  pix_t emitted[$];
  bit   m_last;
  int   m_clip;
  int   m_x, m_y, m_c;
  bit   m_plot;
  int   n_checks = 0;
  int   n_pass = 0;

  vec_t tbl[10];
  int   k0, k1, idx, plots;
  bit   a0, a1, saw_low, saw_rise;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit off_screen(int x, int y);
    return (x >= 160) || (y >= 120);
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_last = 1'b1;
    m_clip = 0;
    m_x = 0; m_y = 0; m_c = 0;
    m_plot = 1'b0;
  endtask

  // One clock edge of the block, from the queue-level behaviour
  task automatic model_edge();
    bit t0, t1, n0, n1;
    pix_t p;
    t0 = bus.s0_valid && (q0.size() != DEPTH);
    t1 = bus.s1_valid && (q1.size() != DEPTH);
    n0 = q0.size() != 0;
    n1 = q1.size() != 0;
    m_plot = 1'b0;
    p = '0;
    if (n0 && (!n1 || m_last)) begin
      p = q0.pop_front(); m_plot = 1'b1;
      if (n1) m_last = 1'b0;
    end else if (n1) begin
      p = q1.pop_front(); m_plot = 1'b1;
      if (n0) m_last = 1'b1;
    end
    if (m_plot) begin
      m_x = int'(p[17:10]); m_y = int'(p[9:3]); m_c = int'(p[2:0]);
    end
    if (t0) begin
      if (off_screen(int'(bus.s0_x), int'(bus.s0_y))) m_clip++;
      else q0.push_back({bus.s0_x, bus.s0_y, bus.s0_colour});
    end
    if (t1) begin
      if (off_screen(int'(bus.s1_x), int'(bus.s1_y))) m_clip++;
      else q1.push_back({bus.s1_x, bus.s1_y, bus.s1_colour});
    end
    if (m_clip > 255) m_clip = 255;
  endtask

  task automatic drive(bit v0, int x0, int y0, int c0,
                       bit v1, int x1, int y1, int c1);
    bus.s0_valid = v0;  bus.s0_x = 8'(x0);
    bus.s0_y = 7'(y0);  bus.s0_colour = 3'(c0);
    bus.s1_valid = v1;  bus.s1_x = 8'(x1);
    bus.s1_y = 7'(y1);  bus.s1_colour = 3'(c1);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    chk("s0_ready", int'(bus.s0_ready), int'(q0.size() != DEPTH));
    chk("s1_ready", int'(bus.s1_ready), int'(q1.size() != DEPTH));
    model_edge();
    @(posedge clock); #1;
    if (bus.plot) emitted.push_back({bus.x, bus.y, bus.colour});
    chk("plot", int'(bus.plot), int'(m_plot));
    chk("x", int'(bus.x), m_x);
    chk("y", int'(bus.y), m_y);
    chk("colour", int'(bus.colour), m_c);
    chk("clip_count", int'(bus.clip_count), m_clip);
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    emitted.delete();
  endtask

  initial begin
    tbl[0] = '{1, 10, 20, 4,   0, 0, 0, 0,    0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0,     0, 0, 0, 0,    1, 10, 20, 4, 0};
    tbl[2] = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 10, 20, 4, 0};
    tbl[3] = '{1, 160, 5, 1,   1, 3, 120, 2,  0, 10, 20, 4, 2};
    tbl[4] = '{1, 159, 119, 7, 0, 0, 0, 0,    0, 10, 20, 4, 2};
    tbl[5] = '{0, 0, 0, 0,     1, 0, 0, 3,    1, 159, 119, 7, 2};
    tbl[6] = '{0, 0, 0, 0,     0, 0, 0, 0,    1, 0, 0, 3, 2};
    tbl[7] = '{0, 0, 0, 0,     0, 0, 0, 0,    0, 0, 0, 3, 2};
    tbl[8] = '{1, 255, 127, 5, 1, 0, 119, 6,  0, 0, 0, 3, 3};
    tbl[9] = '{0, 0, 0, 0,     0, 0, 0, 0,    1, 0, 119, 6, 3};

    idle();
    apply_reset();
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_colour", int'(bus.colour), 0);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_clip", int'(bus.clip_count), 0);
    chk("rst_s0_ready", int'(bus.s0_ready), 1);
    chk("rst_s1_ready", int'(bus.s1_ready), 1);

    // Single pixel latency, clipping and hold behaviour
    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].x0, tbl[i].y0, tbl[i].c0,
            tbl[i].v1, tbl[i].x1, tbl[i].y1, tbl[i].c1);
      model_edge();
      @(posedge clock); #1;
      chk($sformatf("v%0d_plot", i), int'(bus.plot), int'(tbl[i].plot));
      chk($sformatf("v%0d_x", i), int'(bus.x), tbl[i].x);
      chk($sformatf("v%0d_y", i), int'(bus.y), tbl[i].y);
      chk($sformatf("v%0d_colour", i), int'(bus.colour), tbl[i].c);
      chk($sformatf("v%0d_clip", i), int'(bus.clip_count), tbl[i].clip);
    end

    // Back-to-back pushes on both sources alternate on the output
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      drive(1, n, 1, 1, 1, 100 + n, 2, 2);
      step();
    end
    idle();
    for (int n = 0; n < 5; n++) step();
    chk("t2_count", emitted.size(), 8);
    for (int n = 0; n < 8 && n < emitted.size(); n++)
      chk("t2_order", int'(emitted[n][17:10]),
          (n % 2 == 0) ? n / 2 : 100 + n / 2);

    // Contention fills source 0; it must hold pixels while not ready
    apply_reset();
    k0 = 0; k1 = 0; saw_low = 0; saw_rise = 0;
    for (int n = 0; n < 24; n++) begin
      drive(1, k0, 10, 1, 1, 50 + k1, 11, 2);
      if (!bus.s0_ready) saw_low = 1;
      else if (saw_low) saw_rise = 1;
      a0 = bus.s0_ready;
      a1 = bus.s1_ready;
      step();
      if (a0) k0++;
      if (a1) k1++;
    end
    idle();
    for (int n = 0; n < 12; n++) step();
    chk("t3_ready_low", int'(saw_low), 1);
    chk("t3_ready_rise", int'(saw_rise), 1);
    idx = 0;
    foreach (emitted[n]) begin
      if (emitted[n][2:0] == 3'd1) begin
        chk("t3_s0_order", int'(emitted[n][17:10]), idx);
        idx++;
      end
    end
    chk("t3_s0_total", idx, k0);

    // Simultaneous clipping, then saturation
    apply_reset();
    drive(1, 160, 5, 1, 1, 3, 120, 2);
    step();
    chk("t4_clip2", int'(bus.clip_count), 2);
    chk("t4_noplot", int'(bus.plot), 0);
    for (int n = 0; n < 150; n++) begin
      drive(1, $urandom_range(160, 255), $urandom_range(0, 127), 1,
            1, $urandom_range(0, 159), $urandom_range(120, 127), 2);
      step();
    end
    idle();
    step();
    chk("t4_saturate", int'(bus.clip_count), 255);
    chk("t4_no_emit", emitted.size(), 0);

    // Asynchronous reset with both FIFOs holding pixels
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      drive(1, n, 3, 5, 1, 20 + n, 4, 6);
      step();
    end
    idle();
    #3;
    reset = 1'b1;
    #1;
    chk("t5_plot", int'(bus.plot), 0);
    chk("t5_s0_ready", int'(bus.s0_ready), 1);
    chk("t5_s1_ready", int'(bus.s1_ready), 1);
    chk("t5_x", int'(bus.x), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    emitted.delete();
    plots = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (bus.plot) plots++;
    end
    chk("t5_stale", plots, 0);

    // Steady single-source stream across several pointer wraps
    apply_reset();
    for (int n = 0; n < 20; n++) begin
      drive(1, n, n + 1, n % 8, 0, 0, 0, 0);
      step();
      if (n > 0)
        chk("t6_latency", int'(bus.plot && bus.x == 8'(n - 1)), 1);
    end
    idle();
    step();
    chk("t6_last", int'(bus.plot && bus.x == 8'd19), 1);
    chk("t6_count", emitted.size(), 20);
    foreach (emitted[n])
      chk("t6_order", int'(emitted[n][17:10]), n);

    // Randomized traffic against the model
    apply_reset();
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 175),
            $urandom_range(0, 127), $urandom_range(0, 7),
            $urandom_range(0, 2) != 0, $urandom_range(0, 175),
            $urandom_range(0, 127), $urandom_range(0, 7));
      step();
    end
    idle();
    for (int n = 0; n < 10; n++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
